// File: rtl/icon_node_buf.sv
// Buffered 2x2 interconnect switching node: self-routed or externally steered inputs,
// per-output round-robin arbitration, per-output FIFO with valid/ready and a contention counter.
module icon_node_buf #(
  parameter int unsigned DATA_W     = 1,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned STAGE      = 8,
  parameter int unsigned GEN_SCB    = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid_0,
  input  logic              i_valid_1,
  output logic              o_ready_0,
  output logic              o_ready_1,
  input  logic [ADDR_W-1:0] i_addr_0,
  input  logic [ADDR_W-1:0] i_addr_1,
  input  logic [DATA_W-1:0] i_data_0,
  input  logic [DATA_W-1:0] i_data_1,
  input  logic              i_scb,
  output logic              o_valid_0,
  output logic              o_valid_1,
  input  logic              i_ready_0,
  input  logic              i_ready_1,
  output logic [ADDR_W-1:0] o_addr_0,
  output logic [ADDR_W-1:0] o_addr_1,
  output logic [DATA_W-1:0] o_data_0,
  output logic [DATA_W-1:0] o_data_1,
  output logic [CNT_W-1:0]  o_conflict_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam int unsigned EntW = ADDR_W + DATA_W;
  localparam logic [OccW-1:0] DepthOcc = OccW'(FIFO_DEPTH);

  typedef logic [EntW-1:0] ent_t;

  logic [1:0]       dst;
  logic             conflict;
  logic [1:0]       full, empty, ready, accept, push, pop;
  logic [1:0]       rr_q, rr_d;
  logic [OccW-1:0]  occ_q [2];
  logic [OccW-1:0]  occ_d [2];
  logic [PtrW-1:0]  wptr_q [2];
  logic [PtrW-1:0]  wptr_d [2];
  logic [PtrW-1:0]  rptr_q [2];
  logic [PtrW-1:0]  rptr_d [2];
  ent_t             mem_q [2][FIFO_DEPTH];
  ent_t             push_ent [2];
  ent_t             head [2];
  logic [CNT_W-1:0] ccnt_q, ccnt_d;

  always_comb begin
    // With external control the two inputs always take opposite outputs.
    dst[0]   = (GEN_SCB != 0) ? i_addr_0[STAGE] : i_scb;
    dst[1]   = (GEN_SCB != 0) ? i_addr_1[STAGE] : ~i_scb;
    conflict = i_valid_0 && i_valid_1 && (dst[0] == dst[1]);

    for (int j = 0; j < 2; j++) begin
      full[j]  = (occ_q[j] == DepthOcc);
      empty[j] = (occ_q[j] == '0);
    end

    ready[0]  = !full[dst[0]] && !(conflict && rr_q[dst[0]]);
    ready[1]  = !full[dst[1]] && !(conflict && !rr_q[dst[1]]);
    accept[0] = i_valid_0 && ready[0];
    accept[1] = i_valid_1 && ready[1];
    pop[0]    = !empty[0] && i_ready_0;
    pop[1]    = !empty[1] && i_ready_1;

    for (int j = 0; j < 2; j++) begin
      push[j]     = (accept[0] && (dst[0] == 1'(j))) || (accept[1] && (dst[1] == 1'(j)));
      push_ent[j] = (accept[0] && (dst[0] == 1'(j))) ? {i_addr_0, i_data_0}
                                                     : {i_addr_1, i_data_1};
      wptr_d[j]   = wptr_q[j] + PtrW'(push[j]);
      rptr_d[j]   = rptr_q[j] + PtrW'(pop[j]);
      occ_d[j]    = occ_q[j] + OccW'(push[j]) - OccW'(pop[j]);
      head[j]     = empty[j] ? '0 : mem_q[j][rptr_q[j]];
    end

    // The favoured input flips only when the contested grant really lands in the FIFO.
    rr_d = rr_q;
    if (conflict && !full[dst[0]]) begin
      rr_d[dst[0]] = ~rr_q[dst[0]];
    end

    ccnt_d = ccnt_q;
    if (conflict && (ccnt_q != '1)) begin
      ccnt_d = ccnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_q   <= '0;
      ccnt_q <= '0;
      for (int j = 0; j < 2; j++) begin
        occ_q[j]  <= '0;
        wptr_q[j] <= '0;
        rptr_q[j] <= '0;
      end
    end else begin
      rr_q   <= rr_d;
      ccnt_q <= ccnt_d;
      for (int j = 0; j < 2; j++) begin
        occ_q[j]  <= occ_d[j];
        wptr_q[j] <= wptr_d[j];
        rptr_q[j] <= rptr_d[j];
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    for (int j = 0; j < 2; j++) begin
      if (push[j]) begin
        mem_q[j][wptr_q[j]] <= push_ent[j];
      end
    end
  end

  assign o_ready_0             = ready[0];
  assign o_ready_1             = ready[1];
  assign o_valid_0             = !empty[0];
  assign o_valid_1             = !empty[1];
  assign {o_addr_0, o_data_0}  = head[0];
  assign {o_addr_1, o_data_1}  = head[1];
  assign o_conflict_cnt        = ccnt_q;

endmodule

// File: tb/tb_icon_node_buf.sv
// Self-checking bench for icon_node_buf: directed tables and sequences plus random traffic
// compared against a queue-based model of the node.
module tb_icon_node_buf;

  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int STG   = 8;

  logic clk = 1'b0;
  logic rst;
  logic v0, v1, r0, r1, scb;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] x0, x1;

  logic or0, or1, ov0, ov1;
  logic [AW-1:0] oa0, oa1;
  logic [DW-1:0] od0, od1;
  logic [15:0] cnt;

  logic s_or0, s_or1, s_ov0, s_ov1;
  logic [AW-1:0] s_oa0, s_oa1;
  logic [DW-1:0] s_od0, s_od1;
  logic [15:0] s_cnt;

  logic t_or0, t_or1, t_ov0, t_ov1;
  logic [AW-1:0] t_oa0, t_oa1;
  logic [DW-1:0] t_od0, t_od1;
  logic [2:0] t_cnt;

  always #5 clk = ~clk;

  icon_node_buf #(.DATA_W(DW), .ADDR_W(AW), .STAGE(STG), .GEN_SCB(1), .FIFO_DEPTH(DEPTH),
                  .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid_0(v0), .i_valid_1(v1), .o_ready_0(or0), .o_ready_1(or1),
    .i_addr_0(a0), .i_addr_1(a1), .i_data_0(x0), .i_data_1(x1), .i_scb(scb),
    .o_valid_0(ov0), .o_valid_1(ov1), .i_ready_0(r0), .i_ready_1(r1),
    .o_addr_0(oa0), .o_addr_1(oa1), .o_data_0(od0), .o_data_1(od1), .o_conflict_cnt(cnt));

  icon_node_buf #(.DATA_W(DW), .ADDR_W(AW), .STAGE(STG), .GEN_SCB(0), .FIFO_DEPTH(DEPTH),
                  .CNT_W(16)) u_scb (
    .i_clk(clk), .i_rst(rst), .i_valid_0(v0), .i_valid_1(v1), .o_ready_0(s_or0),
    .o_ready_1(s_or1), .i_addr_0(a0), .i_addr_1(a1), .i_data_0(x0), .i_data_1(x1), .i_scb(scb),
    .o_valid_0(s_ov0), .o_valid_1(s_ov1), .i_ready_0(r0), .i_ready_1(r1),
    .o_addr_0(s_oa0), .o_addr_1(s_oa1), .o_data_0(s_od0), .o_data_1(s_od1),
    .o_conflict_cnt(s_cnt));

  icon_node_buf #(.DATA_W(DW), .ADDR_W(AW), .STAGE(STG), .GEN_SCB(1), .FIFO_DEPTH(DEPTH),
                  .CNT_W(3)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_valid_0(v0), .i_valid_1(v1), .o_ready_0(t_or0),
    .o_ready_1(t_or1), .i_addr_0(a0), .i_addr_1(a1), .i_data_0(x0), .i_data_1(x1), .i_scb(scb),
    .o_valid_0(t_ov0), .o_valid_1(t_ov1), .i_ready_0(r0), .i_ready_1(r1),
    .o_addr_0(t_oa0), .o_addr_1(t_oa1), .o_data_0(t_od0), .o_data_1(t_od1),
    .o_conflict_cnt(t_cnt));

  // Reference model: one queue per output, favoured-input bit per output, contention count.
  logic [AW+DW-1:0] q0[$];
  logic [AW+DW-1:0] q1[$];
  bit   rr[2];
  int   mcnt;
  int   n_chk = 0;
  int   n_err = 0;
  logic [DW-1:0] got0[$];

  // Values sampled from the DUTs during the last step.
  logic smp_or0, smp_or1, smp_ov0, smp_ov1;
  logic [AW-1:0] smp_oa0, smp_oa1;
  logic [DW-1:0] smp_od0, smp_od1;
  logic [15:0] smp_cnt;
  logic smp_s_or0, smp_s_or1, smp_s_ov0, smp_s_ov1;
  logic [DW-1:0] smp_s_od0, smp_s_od1;
  logic [15:0] smp_s_cnt;
  logic [2:0] smp_t_cnt;

  typedef struct {
    logic          v0, v1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] x0, x1;
    logic          er0, er1, ev1;
    logic [DW-1:0] ed1;
    int            ecnt;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    rr[0] = 0;
    rr[1] = 0;
    mcnt  = 0;
  endtask

  task automatic do_reset();
    v0 = 0; v1 = 0; r0 = 1; r1 = 1; scb = 0;
    a0 = '0; a1 = '0; x0 = '0; x1 = '0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    chk("rst_ready0", or0, 1); chk("rst_ready1", or1, 1);
    chk("rst_valid0", ov0, 0); chk("rst_valid1", ov1, 0);
    chk("rst_out0", {oa0, od0}, 0); chk("rst_out1", {oa1, od1}, 0);
    chk("rst_cnt", cnt, 0);
  endtask

  task automatic step(input logic iv0, input logic [AW-1:0] ia0, input logic [DW-1:0] ix0,
                      input logic iv1, input logic [AW-1:0] ia1, input logic [DW-1:0] ix1,
                      input logic ir0, input logic ir1, input logic iscb);
    int  dd0, dd1;
    bit  conf, fd0, fd1, er0, er1, ev0, ev1;
    logic [AW+DW-1:0] h0, h1;
    @(negedge clk);
    v0 = iv0; a0 = ia0; x0 = ix0; v1 = iv1; a1 = ia1; x1 = ix1; r0 = ir0; r1 = ir1; scb = iscb;
    #1;
    dd0  = int'(ia0[STG]);
    dd1  = int'(ia1[STG]);
    conf = iv0 && iv1 && (dd0 == dd1);
    fd0  = (dd0 == 1) ? (q1.size() == DEPTH) : (q0.size() == DEPTH);
    fd1  = (dd1 == 1) ? (q1.size() == DEPTH) : (q0.size() == DEPTH);
    er0  = !fd0 && !(conf && rr[dd0] != 0);
    er1  = !fd1 && !(conf && rr[dd1] != 1);
    ev0  = q0.size() != 0;
    ev1  = q1.size() != 0;
    h0   = ev0 ? q0[0] : '0;
    h1   = ev1 ? q1[0] : '0;
    chk("m_ready0", or0, er0); chk("m_ready1", or1, er1);
    chk("m_valid0", ov0, ev0); chk("m_valid1", ov1, ev1);
    chk("m_out0", {oa0, od0}, h0); chk("m_out1", {oa1, od1}, h1);
    chk("m_cnt", cnt, mcnt);
    smp_or0 = or0; smp_or1 = or1; smp_ov0 = ov0; smp_ov1 = ov1;
    smp_oa0 = oa0; smp_oa1 = oa1; smp_od0 = od0; smp_od1 = od1; smp_cnt = cnt;
    smp_s_or0 = s_or0; smp_s_or1 = s_or1; smp_s_ov0 = s_ov0; smp_s_ov1 = s_ov1;
    smp_s_od0 = s_od0; smp_s_od1 = s_od1; smp_s_cnt = s_cnt; smp_t_cnt = t_cnt;
    if (ov0 && ir0) got0.push_back(od0);
    @(posedge clk);
    if (ev0 && ir0) void'(q0.pop_front());
    if (ev1 && ir1) void'(q1.pop_front());
    if (iv0 && er0) begin
      if (dd0 == 1) q1.push_back({ia0, ix0}); else q0.push_back({ia0, ix0});
    end
    if (iv1 && er1) begin
      if (dd1 == 1) q1.push_back({ia1, ix1}); else q0.push_back({ia1, ix1});
    end
    if (conf && !fd0) rr[dd0] = !rr[dd0];
    if (conf && mcnt < 65535) mcnt++;
  endtask

  initial begin
    int n;
    tbl[0] = '{1, 1, 9'h100, 9'h100, 8'hA, 8'hB, 1, 0, 0, 8'h0, 0};
    tbl[1] = '{1, 1, 9'h100, 9'h100, 8'hA, 8'hB, 0, 1, 1, 8'hA, 1};
    tbl[2] = '{1, 1, 9'h100, 9'h100, 8'hA, 8'hB, 1, 0, 1, 8'hB, 2};
    tbl[3] = '{1, 1, 9'h100, 9'h100, 8'hA, 8'hB, 0, 1, 1, 8'hA, 3};
    tbl[4] = '{0, 0, 9'h000, 9'h000, 8'h0, 8'h0, 1, 1, 1, 8'hB, 4};
    tbl[5] = '{0, 0, 9'h000, 9'h000, 8'h0, 8'h0, 1, 1, 0, 8'h0, 4};

    // Straight routing.
    do_reset();
    step(1, 9'h005, 8'h11, 1, 9'h1A0, 8'h22, 1, 1, 0);
    step(0, 9'h000, 8'h00, 0, 9'h000, 8'h00, 1, 1, 0);
    chk("str_v0", smp_ov0, 1); chk("str_a0", smp_oa0, 9'h005); chk("str_d0", smp_od0, 8'h11);
    chk("str_v1", smp_ov1, 1); chk("str_a1", smp_oa1, 9'h1A0); chk("str_d1", smp_od1, 8'h22);
    chk("str_cnt", smp_cnt, 0);

    // Conflict round-robin.
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].v0, tbl[i].a0, tbl[i].x0, tbl[i].v1, tbl[i].a1, tbl[i].x1, 1, 1, 0);
      chk("rr_ready0", smp_or0, tbl[i].er0); chk("rr_ready1", smp_or1, tbl[i].er1);
      chk("rr_valid1", smp_ov1, tbl[i].ev1); chk("rr_data1", smp_od1, tbl[i].ed1);
      chk("rr_cnt", smp_cnt, tbl[i].ecnt);
    end

    // Backpressure and full.
    do_reset();
    got0.delete();
    n = 1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      step(n <= 6, AW'(n), DW'(n), 0, 9'h000, 8'h00, cyc >= 6, 1, 0);
      if (cyc < 9) chk("bp_ready0", smp_or0, (cyc < 4 || cyc >= 7));
      if (n <= 6 && smp_or0) n++;
    end
    chk("bp_count", got0.size(), 6);
    for (int i = 0; i < got0.size(); i++) chk("bp_order", got0[i], i + 1);

    // External control.
    do_reset();
    step(1, 9'h1FF, 8'h01, 1, 9'h1FF, 8'h02, 1, 1, 1);
    chk("scb_ready0", smp_s_or0, 1); chk("scb_ready1", smp_s_or1, 1);
    step(1, 9'h000, 8'h03, 1, 9'h000, 8'h04, 1, 1, 0);
    chk("scb_ready0b", smp_s_or0, 1); chk("scb_ready1b", smp_s_or1, 1);
    chk("scb_d1", smp_s_od1, 8'h01); chk("scb_d0", smp_s_od0, 8'h02);
    step(0, 9'h000, 8'h00, 0, 9'h000, 8'h00, 1, 1, 0);
    chk("scb_d0b", smp_s_od0, 8'h03); chk("scb_d1b", smp_s_od1, 8'h04);
    chk("scb_cnt", smp_s_cnt, 0);

    // Counter saturation.
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      step(i < 10, 9'h000, 8'h00, i < 10, 9'h000, 8'h00, 1, 1, 0);
      chk("sat_cnt", smp_t_cnt, (i < 7) ? i : 7);
    end

    // Reset mid-operation.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 9'h000, DW'(i), 1, 9'h000, DW'(i + 8), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 9'h100, DW'(i), 1, 9'h100, DW'(i + 8), 0, 0, 0);
    step(0, 9'h000, 8'h00, 0, 9'h000, 8'h00, 1, 0, 0);
    step(0, 9'h000, 8'h00, 0, 9'h000, 8'h00, 0, 0, 0);
    chk("mid_cnt7", smp_cnt, 7); chk("mid_v0", smp_ov0, 1); chk("mid_v1", smp_ov1, 1);
    #2;
    v0 = 0; v1 = 0;
    rst = 1;
    #1;
    chk("mid_rst_v0", ov0, 0); chk("mid_rst_v1", ov1, 0);
    chk("mid_rst_d0", od0, 0); chk("mid_rst_d1", od1, 0);
    chk("mid_rst_cnt", cnt, 0);
    #1;
    rst = 0;
    model_reset();
    step(1, 9'h0AB, 8'h5A, 0, 9'h000, 8'h00, 1, 1, 0);
    step(0, 9'h000, 8'h00, 0, 9'h000, 8'h00, 1, 1, 0);
    chk("mid_new_v0", smp_ov0, 1); chk("mid_new_d0", smp_od0, 8'h5A);
    chk("mid_new_a0", smp_oa0, 9'h0AB);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(1)), AW'($urandom), DW'($urandom),
           1'($urandom_range(1)), AW'($urandom), DW'($urandom),
           $urandom_range(3) != 0, $urandom_range(3) != 0, 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/icon_node_buf.md
# icon_node_buf

Buffered 2x2 switching node for the multi-stage interconnect, the next generation of the unbuffered routing node. Each input is steered to output `i_addr_k[STAGE]` (self-routing) or by an external straight/cross control. Output contention is resolved by per-output round-robin arbitration, and each output has a FIFO with valid/ready backpressure. A per-node saturating counter records contention cycles for network profiling.

## Interface
- `DATA_W`, 1: payload width.
- `ADDR_W`, 9: address width.
- `STAGE`, 8: address bit used for routing; range 0..ADDR_W-1.
- `GEN_SCB`, 1: 1 = route each input by its own `i_addr_k[STAGE]`; 0 = route both inputs by `i_scb` (0 straight, 1 cross).
- `FIFO_DEPTH`, 4: entries per output FIFO; power of two, at least 2.
- `CNT_W`, 16: width of the contention counter.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_valid_0` / `i_valid_1`  in  1  input flit valid.
- `o_ready_0` / `o_ready_1`  out  1  input flit accepted this cycle if valid.
- `i_addr_0` / `i_addr_1`  in  ADDR_W  flit address.
- `i_data_0` / `i_data_1`  in  DATA_W  flit payload.
- `i_scb`  in  1  external switch control; used only when GEN_SCB=0.
- `o_valid_0` / `o_valid_1`  out  1  output flit valid.
- `i_ready_0` / `i_ready_1`  in  1  downstream ready.
- `o_addr_0` / `o_addr_1`  out  ADDR_W  output flit address, passed through unmodified.
- `o_data_0` / `o_data_1`  out  DATA_W  output flit payload.
- `o_conflict_cnt`  out  CNT_W  saturating count of contention cycles.

## Operation
- **Destination:** `d_k = GEN_SCB ? i_addr_k[STAGE] : (i_scb ^ k)`.
  - GEN_SCB=0 can never produce contention.
- **Conflict:** `i_valid_0 && i_valid_1 && d_0 == d_1`.
- **Arbiter, one per output j:**
  - State is a single `rr_j` bit naming the favoured input; reset value 0.
  - On conflict for j, input `rr_j` wins.
  - `rr_j` toggles only on a cycle where a conflicting grant is actually accepted (FIFO j not full).
  - Non-conflict accepts leave `rr_j` unchanged.
- **Ready:** `o_ready_k = !full[d_k] && !(conflict && rr_{d_k} != k)`.
  - Ready may depend combinationally on valid and address.
  - Valid must never depend on ready.
- **Accept:** `i_valid_k && o_ready_k` pushes `{addr, data}` into FIFO `d_k`. At most one push per FIFO per cycle.
- **Output FIFO j:**
  - Pop when `o_valid_j && i_ready_j`.
  - `o_valid_j = !empty_j`.
  - `o_addr_j` / `o_data_j` = head entry; forced to 0 when empty.
  - Occupancy counter is clog2(FIFO_DEPTH)+1 bits; read and write pointers wrap modulo FIFO_DEPTH.
- **Full:** a full FIFO blocks push even if a pop happens the same cycle. There is no same-cycle full pass-through.
- **Empty:** no bypass. Push and pop in the same cycle at occupancy ≥1 leaves occupancy unchanged.
- **Counter:** `o_conflict_cnt` increments on every cycle where conflict is true, whether or not the winner is accepted. It saturates at 2^CNT_W-1.
- **Ordering:** flits from one input to one output leave in arrival order.
- **Reset:** asserting `i_rst` at any time immediately empties both FIFOs and clears `rr_0`, `rr_1` and the counter. In-flight flits are discarded.

## Timing
- **Reset values:**
  - `o_valid_0`, `o_valid_1`, `o_addr_*`, `o_data_*`, `o_conflict_cnt` = 0.
  - `o_ready_k` = 1, since FIFOs are empty and there is no conflict.
- **Latency:** a flit accepted at clock edge t is presented (`o_valid` high) in the cycle after edge t, i.e. 1 cycle minimum.
- **Throughput:** each output sustains 1 flit/cycle with `i_ready` held high. Under permanent contention, each input gets 1 flit per 2 cycles.
- **Stall stability:** while `o_valid_j && !i_ready_j`, `o_addr_j` and `o_data_j` hold stable.
- **Full timing:** a full FIFO deasserts the matching `o_ready_k` combinationally in the same cycle.

## Test plan
- **Straight routing:** reset, GEN_SCB=1. `i_addr_0=0x005`, `i_addr_1=0x1A0`, both valid for one cycle. Next cycle: `o_valid_0=1`, `o_addr_0=0x005`; `o_valid_1=1`, `o_addr_1=0x1A0`; counter stays 0.
- **Conflict round-robin:** both inputs valid with addr bit 8 = 1 for 4 cycles, data 0xA/0xB, `i_ready_1=1`.
  - `o_ready` alternates: input 0 in cycle 0, input 1 in cycle 1, and so on.
  - `o_data_1` sequence is A, B, A, B.
  - Counter reaches 4.
- **Backpressure/full:** FIFO_DEPTH=4, `i_ready_0=0`, input 0 streams 6 flits to output 0.
  - `o_ready_0` drops after 4 accepts.
  - Release `i_ready_0`; exactly 4 flits emerge in order, then the remaining 2.
  - No loss or duplication.
- **External control:** GEN_SCB=0, `i_scb=1`. Inputs 0 and 1 carry data 0x1 and 0x2. Result: `o_data_1=0x1`, `o_data_0=0x2`. `o_ready` stays high and the counter stays 0 regardless of addresses.
- **Reset mid-operation:** with both FIFOs holding 3 entries and counter at 7, pulse `i_rst` asynchronously between clock edges.
  - Immediately: `o_valid_*=0`, `o_data_*=0`, counter=0.
  - Afterwards, a new flit is delivered with 1-cycle latency.
- **Counter saturation:** CNT_W=3 with 10 consecutive conflict cycles. `o_conflict_cnt` stops at 7.
